// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded micro-op fields into 32-bit words
// and queues them in a small output FIFO behind a valid/ready handshake.
module inst_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [31:0]      imm,
    input  logic [2:0]       alu_op,
    input  logic             alu_src,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SRA = 3'b011,
        ALU_AND = 3'b100
    } alu_op_e;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } opcode_e;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   occ;
    logic          push;
    logic          pop;

    // imm[31:12] never reaches the encoded word
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:12];

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = NOP;
        funct3    = 3'b000;
        funct7    = 7'b0000000;
        if (mem_read && mem_write) begin
            enc_legal = 1'b0;
        end else if (mem_write) begin
            enc_legal = (alu_op == ALU_ADD) && !reg_write;
            enc_word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
        end else if (mem_read) begin
            enc_legal = (alu_op == ALU_ADD) && reg_write;
            enc_word  = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        end else if (alu_src) begin
            case (alu_op)
                ALU_ADD: funct3 = 3'b000;
                ALU_AND: funct3 = 3'b111;
                default: enc_legal = 1'b0;
            endcase
            enc_legal = enc_legal && reg_write;
            enc_word  = {imm[11:0], rs1, funct3, rd, OP_IMM};
        end else begin
            case (alu_op)
                ALU_ADD: begin funct7 = 7'b0000000; funct3 = 3'b000; end
                ALU_SUB: begin funct7 = 7'b0100000; funct3 = 3'b000; end
                ALU_XOR: begin funct7 = 7'b0000000; funct3 = 3'b100; end
                ALU_SRA: begin funct7 = 7'b0100000; funct3 = 3'b101; end
                default: enc_legal = 1'b0;
            endcase
            enc_legal = enc_legal && reg_write;
            enc_word  = {funct7, rs2, rs1, funct3, rd, OP_REG};
        end
        if (!enc_legal) begin
            enc_word = NOP;
        end
    end

    // Full blocks a push even when a pop frees a slot in the same cycle
    assign in_ready  = (occ != (AW+1)'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign inst      = out_valid ? mem[head] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            illegal    <= 1'b0;
            inst_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
                if (!enc_legal) begin
                    illegal <= 1'b1;
                end
            end
            if (pop) begin
                head       <= head + AW'(1);
                inst_count <= inst_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed instruction words.
module tb_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic [2:0]  alu_op = '0;
    logic        alu_src = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] inst;
    logic        illegal;
    logic [15:0] inst_count;

    int tests = 0;
    int fails = 0;
    bit checking = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        src, mr, mw, rw;
    } bundle_t;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .inst(inst), .illegal(illegal), .inst_count(inst_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference encoder written from the field-placement rules
    function automatic logic [31:0] model_enc(input bundle_t b, output bit bad);
        int f3_r[4] = '{0, 0, 4, 5};
        int f7_r[4] = '{0, 'h20, 0, 'h20};
        logic [31:0] i12 = b.imm & 32'hFFF;
        logic [31:0] w = 0;
        int f3 = 0;
        int f7 = 0;
        int op = int'(b.op);
        bad = 0;
        if (b.mr && b.mw) begin
            bad = 1;
        end else if (b.mw) begin
            bad = (op != 0) || b.rw;
            w = ((i12 >> 5) << 25) + (32'(b.rs2) << 20) + (32'(b.rs1) << 15)
                + (2 << 12) + ((i12 & 31) << 7) + 'h23;
        end else if (b.mr) begin
            bad = (op != 0) || !b.rw;
            w = (i12 << 20) + (32'(b.rs1) << 15) + (2 << 12) + (32'(b.rd) << 7) + 'h03;
        end else if (b.src) begin
            if (op == 0) f3 = 0;
            else if (op == 4) f3 = 7;
            else bad = 1;
            bad = bad || !b.rw;
            w = (i12 << 20) + (32'(b.rs1) << 15) + (32'(f3) << 12) + (32'(b.rd) << 7) + 'h13;
        end else begin
            if (op < 4) begin f3 = f3_r[op]; f7 = f7_r[op]; end
            else bad = 1;
            bad = bad || !b.rw;
            w = (32'(f7) << 25) + (32'(b.rs2) << 20) + (32'(b.rs1) << 15)
                + (32'(f3) << 12) + (32'(b.rd) << 7) + 'h33;
        end
        return bad ? 32'h13 : w;
    endfunction

    logic [31:0] mq[$];
    bit          m_ill = 0;
    logic [15:0] m_cnt = 0;

    always @(posedge clk) begin
        bundle_t b;
        bit bad, do_push, do_pop;
        logic [31:0] w;
        if (rst) begin
            mq.delete();
            m_ill = 0;
            m_cnt = 0;
        end else begin
            b = '{rs1, rs2, rd, imm, alu_op, alu_src, mem_read, mem_write, reg_write};
            w = model_enc(b, bad);
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (do_push) begin
                mq.push_back(w);
                if (bad) m_ill = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("m_inst", inst, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("m_illegal", 32'(illegal), 32'(m_ill));
            chk("m_inst_count", 32'(inst_count), 32'(m_cnt));
        end
    end

    function automatic bundle_t mk(input logic [2:0] op, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [31:0] im, input logic src,
                                   input logic mr, input logic mw, input logic rw);
        bundle_t b;
        b.op = op; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = im;
        b.src = src; b.mr = mr; b.mw = mw; b.rw = rw;
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents a bundle and returns #1 after the accepting edge
    task automatic push(input bundle_t b);
        bit done = 0;
        rs1 = b.rs1; rs2 = b.rs2; rd = b.rd; imm = b.imm; alu_op = b.op;
        alu_src = b.src; mem_read = b.mr; mem_write = b.mw; reg_write = b.rw;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got in_ready=0 expected accept within 50 cycles");
        end
    endtask

    initial begin
        int t0;
        do_reset();
        checking = 1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_inst", inst, 0);
        chk("rst_count", 32'(inst_count), 0);

        // single ops, FIFO drains every cycle
        out_ready = 1'b1;
        push(mk(3'b000, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("add_valid", 32'(out_valid), 1);
        chk("add", inst, 32'h002081B3);
        @(posedge clk); #1;
        chk("add_count", 32'(inst_count), 1);
        push(mk(3'b001, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("sub", inst, 32'h402081B3);
        push(mk(3'b011, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("sra", inst, 32'h4020D1B3);
        push(mk(3'b000, 5, 0, 0, 10, 1, 0, 0, 1));
        chk("addi", inst, 32'h00A00293);
        push(mk(3'b100, 6, 1, 0, 32'hFF, 1, 0, 0, 1));
        chk("andi", inst, 32'h0FF0F313);
        push(mk(3'b000, 4, 1, 0, 4, 1, 1, 0, 1));
        chk("lw", inst, 32'h0040A203);
        push(mk(3'b000, 0, 1, 2, 8, 1, 0, 1, 0));
        chk("sw", inst, 32'h0020A423);
        @(posedge clk); #1;
        chk("single_count", 32'(inst_count), 7);
        chk("single_illegal", 32'(illegal), 0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(mk(3'b000, 5'(i), 1, 2, 0, 0, 0, 0, 1));
        chk("bp_full_ready", 32'(in_ready), 0);
        chk("bp_head", inst, 32'h002080B3);
        fork
            push(mk(3'b000, 5, 1, 2, 0, 0, 0, 0, 1));
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && out_valid; i++) begin @(posedge clk); #1; end
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_count", 32'(inst_count), 5);

        // illegal bundles
        do_reset();
        out_ready = 1'b1;
        push(mk(3'b000, 3, 1, 2, 0, 0, 1, 1, 1));
        chk("ill_nop", inst, 32'h00000013);
        chk("ill_flag", 32'(illegal), 1);
        push(mk(3'b000, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("ill_add", inst, 32'h002081B3);
        chk("ill_sticky", 32'(illegal), 1);
        push(mk(3'b100, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("ill_r_and", inst, 32'h00000013);
        push(mk(3'b001, 3, 1, 2, 0, 1, 0, 0, 1));
        chk("ill_i_sub", inst, 32'h00000013);
        push(mk(3'b000, 0, 1, 2, 8, 1, 0, 1, 1));
        chk("ill_sw_rw", inst, 32'h00000013);

        // back-to-back stream
        do_reset();
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            push(mk(3'(i % 4), 5'(i), 5'(i + 1), 5'(31 - i), 0, 0, 0, 0, 1));
            tests++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stream_valid: got %b expected 1 at word %0d", out_valid, i);
            end
        end
        chk("stream_cycles", 32'(cyc - t0), 20);
        @(posedge clk); #1;
        chk("stream_count", 32'(inst_count), 20);

        // reset mid-stream
        out_ready = 1'b0;
        push(mk(3'b000, 3, 1, 2, 0, 0, 1, 1, 1));
        push(mk(3'b000, 3, 1, 2, 0, 0, 0, 0, 1));
        push(mk(3'b001, 3, 1, 2, 0, 0, 0, 0, 1));
        chk("pre_rst_illegal", 32'(illegal), 1);
        chk("pre_rst_count", 32'(inst_count), 20);
        do_reset();
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_illegal", 32'(illegal), 0);
        chk("post_rst_count", 32'(inst_count), 0);
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("post_rst_inst", inst, 0);

        repeat (2) @(posedge clk);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RV32I instruction encoder: the inverse of the front-end decode stage. Accepts decoded micro-op fields (register indices, immediate, ALU op and control bits) over a valid/ready handshake, packs them into 32-bit RV32I instruction words, and delivers them through a small output FIFO. Used to build instruction-memory images and by the self-checking CPU benches to round-trip fields through decode. Supported ops are ADD, SUB, XOR, SRA, ADDI, ANDI, LW and SW, with the same alu_op code points as decode.

## Interface
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of inst_count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- rs1 / rs2 / rd  in  5 each  register indices.
- imm  in  32  immediate; only imm[11:0] is encoded.
- alu_op  in  3  000 ADD, 001 SUB, 010 XOR, 011 SRA, 100 AND.
- alu_src  in  1  1 = immediate operand.
- mem_read / mem_write / reg_write  in  1 each  control bits as produced by decode.
- out_valid  out  1  inst holds a valid word (FIFO head).
- out_ready  in  1  consumer takes the word when out_valid is also high.
- inst  out  32  encoded instruction at the FIFO head.
- illegal  out  1  sticky flag: an unencodable bundle was accepted.
- inst_count  out  CNT_W  number of words popped since reset.

## Operation
- Accept when in_valid && in_ready. The word is encoded combinationally and written to the FIFO tail in the same edge.
- Selection by priority, first match wins:
  - mem_read && mem_write: illegal.
  - mem_write: SW. Opcode 0100011, funct3 010, imm[11:5] to [31:25], imm[4:0] to [11:7], rs2 and rs1 in their standard fields. Requires alu_op=000 and reg_write=0.
  - mem_read: LW. Opcode 0000011, funct3 010, imm[11:0] to [31:20], rd, rs1. Requires alu_op=000 and reg_write=1.
  - alu_src: I-type, opcode 0010011. alu_op 000 gives ADDI (funct3 000); alu_op 100 gives ANDI (funct3 111). Any other alu_op is illegal. Requires reg_write=1.
  - otherwise: R-type, opcode 0110011.
    - 000 ADD: funct7 0000000, funct3 000.
    - 001 SUB: funct7 0100000, funct3 000.
    - 010 XOR: funct7 0000000, funct3 100.
    - 011 SRA: funct7 0100000, funct3 101.
    - Any other alu_op is illegal. Requires reg_write=1. imm is ignored.
- Fields that are unused by the selected format are not encoded.
- imm[31:12] is ignored; no range check is made.
- An illegal bundle is still accepted. It pushes the canonical NOP 0x00000013 and sets illegal, which stays set until rst.
- A pop occurs when out_valid && out_ready. Each pop advances the head and increments inst_count, which wraps modulo 2^CNT_W.

## Timing
- Reset values: out_valid=0, illegal=0, inst_count=0, FIFO empty. in_ready=1 from the first cycle after reset. inst is 0 while empty.
- Latency: a bundle accepted at edge N appears on inst with out_valid=1 after edge N when the FIFO was empty. FIFO order is strictly preserved.
- in_ready = !full, registered-count based.
  - When the FIFO is full, no push is allowed even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- Simultaneous push and pop when not full: occupancy is unchanged and both the head and tail pointers advance.
- Empty FIFO with out_ready=1: no pop and no count change.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- The producer must hold its fields stable while in_valid=1 and in_ready=0.
- out_valid only falls by a pop. inst stays stable while out_valid=1 and out_ready=0.
- rst asserted mid-stream: all buffered words are discarded, illegal and inst_count clear, and outputs return to reset values at the next edge.

## Test plan
- Single ops into an empty FIFO, out_ready=1:
  - ADD rd=3 rs1=1 rs2=2 gives 0x002081B3.
  - SUB gives 0x402081B3.
  - SRA gives 0x4020D1B3.
  - Each word appears one cycle after accept, and inst_count increments.
- I-type and memory ops:
  - ADDI rd=5 rs1=0 imm=10 gives 0x00A00293.
  - ANDI rd=6 rs1=1 imm=0xFF gives 0x0FF0F313.
  - LW rd=4 rs1=1 imm=4 gives 0x0040A203.
  - SW rs1=1 rs2=2 imm=8 gives 0x0020A423.
- Backpressure: out_ready=0, push 5 bundles.
  - in_ready drops after the 4th push.
  - Raising out_ready pops the words in order, and in_ready returns the cycle after the first pop.
  - inst_count ends at 5.
- Illegal inputs:
  - mem_read=mem_write=1 gives 0x00000013 and illegal=1.
  - A following legal ADD still encodes correctly, and illegal stays 1.
- Back-to-back stream: in_valid=1 and out_ready=1 continuously for 20 bundles gives one word per cycle with no bubbles, and inst_count=20.
- Reset with 3 words buffered and illegal=1: after the edge, out_valid=0, illegal=0, inst_count=0, in_ready=1.
